// File: rtl/proc_control_pkg.sv
// Shared definitions for the multicycle processor control path: opcodes, ALU codes,
// timestep encodings and instruction field positions.
package proc_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;
  localparam int OP_W      = 4;
  localparam int OP_MSB    = 15;
  localparam int RX_LSB    = 9;
  localparam int RY_LSB    = 6;

  localparam logic [OP_W-1:0] OP_MV  = 4'b0000;
  localparam logic [OP_W-1:0] OP_MVI = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0110;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SRL: is_alu = 1'b1;
      default:                                is_alu = 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_SLL:  alu_code = ALU_SLL;
      OP_SRL:  alu_code = ALU_SRL;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_reg_dec.sv
// Register-select decoder: turns a binary register index into a one-hot enable vector,
// all zeros when not enabled.
module reg_dec #(
  parameter int SEL_W = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   onehot
);

  // One-hot decode gated by enable
  always_comb begin
    onehot = {(2**SEL_W){1'b0}};
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = {(2**SEL_W){1'b0}};
    end
  end

endmodule

// File: rtl/proc_control.sv
// Multicycle control unit: latches an instruction in T0 and sequences register, bus and
// ALU control over T1..T3. Outputs are decoded combinationally from timestep and IR.
module proc_control
  import proc_pkg::*;
#(
  parameter int DATA_W    = proc_pkg::DATA_W,
  parameter int REG_SEL_W = proc_pkg::REG_SEL_W
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    run,
  input  logic [DATA_W-1:0]       din,
  output logic                    ir_in,
  output logic [2**REG_SEL_W-1:0] r_in,
  output logic [2**REG_SEL_W-1:0] r_out,
  output logic                    a_in,
  output logic                    g_in,
  output logic                    g_out,
  output logic                    din_out,
  output logic [2:0]              alu_op,
  output logic                    busy,
  output logic                    done
);

  localparam int IR_W = OP_MSB - RY_LSB + 1;

  state_t                 state_r, next_state_s;
  logic [IR_W-1:0]        ir_r;
  logic [OP_W-1:0]        op_s;
  logic [REG_SEL_W-1:0]   rx_s, ry_s;
  logic                   rin_en_s, rout_en_s;
  logic [REG_SEL_W-1:0]   rin_sel_s, rout_sel_s;
  logic                   din_unused;

  // Low operand bits of the instruction word carry no meaning
  assign din_unused = ^din[RY_LSB-1:0];

  assign op_s = ir_r[IR_W-1 -: OP_W];
  assign rx_s = ir_r[RX_LSB-RY_LSB +: REG_SEL_W];
  assign ry_s = ir_r[0 +: REG_SEL_W];

  // Timestep register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= T0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction register, loaded only when an instruction is accepted in T0
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ir_r <= {IR_W{1'b0}};
    end else if (state_r == T0 && run) begin
      ir_r <= din[OP_MSB:RY_LSB];
    end else begin
      ir_r <= ir_r;
    end
  end

  // Next-state and control decode; outputs are held low throughout reset
  always_comb begin
    next_state_s = state_r;
    ir_in        = 1'b0;
    rin_en_s     = 1'b0;
    rin_sel_s    = {REG_SEL_W{1'b0}};
    rout_en_s    = 1'b0;
    rout_sel_s   = {REG_SEL_W{1'b0}};
    a_in         = 1'b0;
    g_in         = 1'b0;
    g_out        = 1'b0;
    din_out      = 1'b0;
    alu_op       = 3'b000;
    busy         = 1'b0;
    done         = 1'b0;
    if (!resetn) begin
      next_state_s = T0;
    end else begin
      busy = (state_r != T0);
      case (state_r)
        T0: begin
          ir_in = run;
          if (run) begin
            next_state_s = T1;
          end else begin
            next_state_s = T0;
          end
        end
        T1: begin
          if (is_alu(op_s)) begin
            rout_en_s    = 1'b1;
            rout_sel_s   = rx_s;
            a_in         = 1'b1;
            alu_op       = alu_code(op_s);
            next_state_s = T2;
          end else if (op_s == OP_MV) begin
            rout_en_s    = 1'b1;
            rout_sel_s   = ry_s;
            rin_en_s     = 1'b1;
            rin_sel_s    = rx_s;
            done         = 1'b1;
            next_state_s = T0;
          end else if (op_s == OP_MVI) begin
            din_out      = 1'b1;
            rin_en_s     = 1'b1;
            rin_sel_s    = rx_s;
            done         = 1'b1;
            next_state_s = T0;
          end else begin
            done         = 1'b1;
            next_state_s = T0;
          end
        end
        T2: begin
          rout_en_s    = 1'b1;
          rout_sel_s   = ry_s;
          g_in         = 1'b1;
          alu_op       = alu_code(op_s);
          next_state_s = T3;
        end
        T3: begin
          g_out        = 1'b1;
          rin_en_s     = 1'b1;
          rin_sel_s    = rx_s;
          alu_op       = alu_code(op_s);
          done         = 1'b1;
          next_state_s = T0;
        end
        default: begin
          next_state_s = T0;
        end
      endcase
    end
  end

  reg_dec #(.SEL_W(REG_SEL_W)) u_rin_dec (
    .en     (rin_en_s),
    .sel    (rin_sel_s),
    .onehot (r_in)
  );

  reg_dec #(.SEL_W(REG_SEL_W)) u_rout_dec (
    .en     (rout_en_s),
    .sel    (rout_sel_s),
    .onehot (r_out)
  );

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: directed scenarios plus a randomized instruction
// stream, each cycle compared against a per-instruction behavioural model.
module tb_proc_control;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        ir_in, a_in, g_in, g_out, din_out, busy, done;
  logic [7:0]  r_in, r_out;
  logic [2:0]  alu_op;

  int checks;
  int failures;

  proc_control dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .din_out (din_out),
    .alu_op  (alu_op),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed outputs packed as {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, busy, done}
  function automatic logic [25:0] observed();
    return {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, busy, done};
  endfunction

  // Reference: expected outputs at step t of instruction w (t=0 is the accepting T0 cycle)
  function automatic logic [25:0] model(input logic [15:0] w, input int t, input logic run_in);
    int op, rx, ry;
    logic ir, a, g, go, dout, bsy, dn;
    logic [7:0] ri, ro;
    logic [2:0] alu;
    op = int'(w[15:12]); rx = int'(w[11:9]); ry = int'(w[8:6]);
    ir = 1'b0; a = 1'b0; g = 1'b0; go = 1'b0; dout = 1'b0; bsy = 1'b0; dn = 1'b0;
    ri = 8'h00; ro = 8'h00; alu = 3'b000;
    if (t == 0) begin
      ir = run_in;
    end else begin
      bsy = 1'b1;
      if (op == 0) begin
        ro = 8'h01 << ry; ri = 8'h01 << rx; dn = 1'b1;
      end else if (op == 1) begin
        dout = 1'b1; ri = 8'h01 << rx; dn = 1'b1;
      end else if (op >= 2 && op <= 6) begin
        alu = 3'(op - 2);
        if (t == 1) begin ro = 8'h01 << rx; a = 1'b1; end
        if (t == 2) begin ro = 8'h01 << ry; g = 1'b1; end
        if (t == 3) begin go = 1'b1; ri = 8'h01 << rx; dn = 1'b1; end
      end else begin
        dn = 1'b1;
      end
    end
    return {ir, ri, ro, a, g, go, dout, alu, bsy, dn};
  endfunction

  function automatic int last_step(input logic [15:0] w);
    return (w[15:12] >= 4'd2 && w[15:12] <= 4'd6) ? 3 : 1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction from its T0 through done, checking every cycle
  task automatic run_instr(input string name, input logic [15:0] w, input logic [15:0] imm,
                           input logic hold);
    logic [25:0] exp;
    int n;
    n = last_step(w);
    for (int t = 0; t <= n; t++) begin
      if (t == 0) begin
        din = w; run = 1'b1;
      end else begin
        din = (t == 1) ? imm : 16'($urandom);
        run = hold ? 1'b1 : 1'($urandom);
      end
      #1;
      exp = model(w, t, run);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL %s w=%h step=%0d got=%h want=%h", name, w, t, observed(), exp);
      end
      step();
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      run = 1'b0; din = 16'($urandom);
      #1;
      checks++;
      if (observed() !== 26'h0) begin
        failures++;
        $display("FAIL %s idle=%0d got=%h want=%h", name, i, observed(), 26'h0);
      end
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; run = 1'b0; din = 16'h0000;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (observed() !== 26'h0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, observed(), 26'h0);
      end
      step();
    end
    resetn = 1'b1;
    idle_check("reset_idle", 10);
  endtask

  task automatic test_mvi();
    run_instr("mvi_r3", 16'h1600, 16'h00A5, 1'b0);
    idle_check("mvi_after", 1);
  endtask

  task automatic test_alu_add();
    run_instr("add_r1_r2", 16'h2280, 16'h0000, 1'b0);
    idle_check("add_after", 1);
    run_instr("add_r2_r2", 16'h2480, 16'h0000, 1'b0);
    run_instr("mv_r5_r5", 16'h0B40, 16'h0000, 1'b0);
    idle_check("same_reg_after", 1);
  endtask

  task automatic test_back_to_back();
    run_instr("srl_r0_r7", 16'h61C0, 16'h0000, 1'b1);
    run_instr("b2b_mv_r6_r1", 16'h0C40, 16'h0000, 1'b1);
    run_instr("b2b_sll_r3_r4", 16'h5700, 16'h0000, 1'b0);
    idle_check("b2b_after", 1);
  endtask

  task automatic test_illegal();
    run_instr("illegal_f000", 16'hF000, 16'h0000, 1'b0);
    run_instr("illegal_7e40", 16'h7E40, 16'h0000, 1'b0);
    idle_check("illegal_after", 1);
  endtask

  task automatic test_reset_mid();
    logic [25:0] exp;
    din = 16'h3940; run = 1'b1;
    #1;
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) begin run = 1'b0; #1; end
      exp = model(16'h3940, t, run);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL sub_pre_reset step=%0d got=%h want=%h", t, observed(), exp);
      end
      if (t < 2) step();
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (observed() !== 26'h0) begin
      failures++;
      $display("FAIL reset_in_t2 got=%h want=%h", observed(), 26'h0);
    end
    step();
    resetn = 1'b1;
    idle_check("after_mid_reset", 2);
    run_instr("post_reset_mvi", 16'h1E00, 16'h1234, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(0, 6));
      run_instr("random", w, 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_check("random_gap", $urandom_range(1, 3));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0; run = 1'b0; din = 16'h0000;
    test_reset();
    test_mvi();
    test_alu_add();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
